// File: rtl/cpu_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle field offsets, ALU and
// result-select encodings, and the EX-slot state enum.
package cpu_pkg;

  localparam int CTRLW_DEF       = 10;
  localparam int CTRL_REGWRITE   = 9;
  localparam int CTRL_MEMREAD    = 8;
  localparam int CTRL_MEMWRITE   = 7;
  localparam int CTRL_ALUSRC     = 6;
  localparam int CTRL_ALUOP_LSB  = 3;
  localparam int CTRL_RESSRC_LSB = 1;
  localparam int CTRL_BRANCH     = 0;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } aluOp_e;

  typedef enum logic [1:0] {
    RES_ALU, RES_MEM, RES_PC4, RES_IMM
  } resultSrc_e;

  // The all-zero control word has regWrite/memRead/memWrite/branch clear, so it is a safe bubble.
  typedef enum logic {
    ST_RUN, ST_BUB
  } exState_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, writeback copy, flush/hold controls and registered EX-slot outputs.
// master = decode/pipeline control side, slave = the ID/EX register stage.
interface id_ex_stage_if import cpu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CTRLW = CTRLW_DEF
);
  logic             validD;
  logic [CTRLW-1:0] ctrlD;
  logic [XLEN-1:0]  pcD;
  logic [XLEN-1:0]  immD;
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic [4:0]       rdD;
  logic [XLEN-1:0]  readData1;
  logic [XLEN-1:0]  readData2;
  logic             wbRegWrite;
  logic [4:0]       wbRd;
  logic [XLEN-1:0]  wbData;
  logic             flushE;
  logic             holdE;
  logic             stallD;
  logic             validE;
  logic [CTRLW-1:0] ctrlE;
  logic [XLEN-1:0]  pcE;
  logic [XLEN-1:0]  immE;
  logic [4:0]       rs1E;
  logic [4:0]       rs2E;
  logic [4:0]       rdE;
  logic [XLEN-1:0]  rd1E;
  logic [XLEN-1:0]  rd2E;
  logic [15:0]      bubbleCount;

  modport master (
    output validD, ctrlD, pcD, immD, rs1D, rs2D, rdD, readData1, readData2,
           wbRegWrite, wbRd, wbData, flushE, holdE,
    input  stallD, validE, ctrlE, pcE, immE, rs1E, rs2E, rdE, rd1E, rd2E, bubbleCount
  );

  modport slave (
    input  validD, ctrlD, pcD, immD, rs1D, rs2D, rdD, readData1, readData2,
           wbRegWrite, wbRd, wbData, flushE, holdE,
    output stallD, validE, ctrlE, pcE, immE, rs1E, rs2E, rdE, rd1E, rd2E, bubbleCount
  );
endinterface

// File: rtl/id_ex_stage_wb_bypass.sv
// Combinational writeback-to-read bypass for one source operand; x0 never bypasses.
// Zero latency, no flow control.
module wb_bypass #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rfData,
  input  logic            wbRegWrite,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  output logic [XLEN-1:0] dataOut
);
  assign dataOut = (wbRegWrite && (wbRd != 5'd0) && (wbRd == rs)) ? wbData : rfData;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass and load-use bubble insertion; 1-cycle latency.
// Priority flushE > holdE > bubble > load; stallD freezes decode on hazard or hold.
module id_ex_stage import cpu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CTRLW = CTRLW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);
  localparam logic [CTRLW-1:0] CTRL_NOP = '0;

  exState_e        state;
  exState_e        stateNext;
  logic            hazLU;
  logic            bubble;
  logic [4:0]      rsSel1;
  logic [4:0]      rsSel2;
  logic [XLEN-1:0] rfSel1;
  logic [XLEN-1:0] rfSel2;
  logic [XLEN-1:0] byp1;
  logic [XLEN-1:0] byp2;

  assign hazLU = bus.validE & bus.ctrlE[CTRL_MEMREAD] & (bus.rdE != 5'd0) & bus.validD &
                 ((bus.rdE == bus.rs1D) | (bus.rdE == bus.rs2D));
  assign bubble = hazLU & ~bus.flushE & ~bus.holdE;

  // rst_n gating keeps stallD low while holdE may still be asserted during reset.
  assign bus.stallD = rst_n & ~bus.flushE & (hazLU | bus.holdE);

  // While held, the bypass watches the already-latched operands so a late writeback is not lost.
  assign rsSel1 = bus.holdE ? bus.rs1E : bus.rs1D;
  assign rsSel2 = bus.holdE ? bus.rs2E : bus.rs2D;
  assign rfSel1 = bus.holdE ? bus.rd1E : bus.readData1;
  assign rfSel2 = bus.holdE ? bus.rd2E : bus.readData2;

  wb_bypass #(.XLEN(XLEN)) uByp1 (
    .rs(rsSel1), .rfData(rfSel1), .wbRegWrite(bus.wbRegWrite),
    .wbRd(bus.wbRd), .wbData(bus.wbData), .dataOut(byp1)
  );

  wb_bypass #(.XLEN(XLEN)) uByp2 (
    .rs(rsSel2), .rfData(rfSel2), .wbRegWrite(bus.wbRegWrite),
    .wbRd(bus.wbRd), .wbData(bus.wbData), .dataOut(byp2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (bus.flushE)     stateNext = ST_RUN;
    else if (bus.holdE) stateNext = state;
    else if (bubble)    stateNext = ST_BUB;
    else                stateNext = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.validE      <= 1'b0;
      bus.ctrlE       <= CTRL_NOP;
      bus.pcE         <= '0;
      bus.immE        <= '0;
      bus.rs1E        <= 5'd0;
      bus.rs2E        <= 5'd0;
      bus.rdE         <= 5'd0;
      bus.rd1E        <= '0;
      bus.rd2E        <= '0;
      bus.bubbleCount <= 16'd0;
    end else if (bus.flushE) begin
      bus.validE <= 1'b0;
      bus.ctrlE  <= CTRL_NOP;
    end else if (bus.holdE) begin
      bus.rd1E <= byp1;
      bus.rd2E <= byp2;
    end else if (bubble) begin
      bus.validE <= 1'b0;
      bus.ctrlE  <= CTRL_NOP;
      if (bus.bubbleCount != 16'hFFFF) bus.bubbleCount <= bus.bubbleCount + 16'd1;
    end else begin
      bus.validE <= bus.validD;
      bus.ctrlE  <= bus.ctrlD;
      bus.pcE    <= bus.pcD;
      bus.immE   <= bus.immD;
      bus.rs1E   <= bus.rs1D;
      bus.rs2E   <= bus.rs2D;
      bus.rdE    <= bus.rdD;
      bus.rd1E   <= byp1;
      bus.rd2E   <= byp2;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of single-cycle loads plus load-use, flush, hold and reset sequences.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  id_ex_stage_if #(.XLEN(32), .CTRLW(10)) bus ();

  id_ex_stage #(.XLEN(32), .CTRLW(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vD;
    logic [9:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        wbW;
    logic [4:0]  wbRd;
    logic [31:0] wbD;
    logic        expV;
    logic [31:0] expRd1;
    logic [31:0] expRd2;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [9:0] mkCtrl(logic rw, logic mr, logic mw, logic as,
                                        aluOp_e op, resultSrc_e rs, logic br);
    return {rw, mr, mw, as, op, rs, br};
  endfunction

  function automatic vec_t mkVec(logic vD, logic [9:0] ctrl, logic [31:0] pc,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                 logic [31:0] r1, logic [31:0] r2,
                                 logic wbW, logic [4:0] wbRd, logic [31:0] wbD,
                                 logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.vD = vD; v.ctrl = ctrl; v.pc = pc; v.imm = pc + 32'h1000;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.r1 = r1; v.r2 = r2;
    v.wbW = wbW; v.wbRd = wbRd; v.wbD = wbD;
    v.expV = vD; v.expRd1 = e1; v.expRd2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.validD = v.vD; bus.ctrlD = v.ctrl; bus.pcD = v.pc; bus.immD = v.imm;
    bus.rs1D = v.rs1; bus.rs2D = v.rs2; bus.rdD = v.rd;
    bus.readData1 = v.r1; bus.readData2 = v.r2;
    bus.wbRegWrite = v.wbW; bus.wbRd = v.wbRd; bus.wbData = v.wbD;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] cAlu;
  logic [9:0] cLw;

  initial begin
    testsRun = 0;
    testsFailed = 0;
    cAlu = mkCtrl(1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, RES_ALU, 1'b0);
    cLw  = mkCtrl(1'b1, 1'b1, 1'b0, 1'b1, ALU_ADD, RES_MEM, 1'b0);

    //            vD    ctrl  pc      rs1 rs2 rd  r1      r2      wbW  wbRd wbD     expRd1  expRd2
    vecs[0]  = mkVec(1'b1, cAlu, 32'h40, 1,  2,  4,  32'h5,  32'h6,  1'b0, 0,  32'h0,  32'h5,  32'h6);
    vecs[1]  = mkVec(1'b1, cAlu, 32'h44, 3,  2,  4,  32'h11, 32'h6,  1'b1, 3,  32'h22, 32'h22, 32'h6);
    vecs[2]  = mkVec(1'b1, cAlu, 32'h48, 3,  2,  4,  32'h11, 32'h6,  1'b1, 0,  32'h22, 32'h11, 32'h6);
    vecs[3]  = mkVec(1'b1, cAlu, 32'h4C, 0,  2,  4,  32'h11, 32'h6,  1'b1, 0,  32'h22, 32'h11, 32'h6);
    vecs[4]  = mkVec(1'b1, cAlu, 32'h50, 1,  9,  4,  32'h5,  32'h33, 1'b1, 9,  32'h44, 32'h5,  32'h44);
    vecs[5]  = mkVec(1'b1, cAlu, 32'h54, 7,  7,  4,  32'h1,  32'h2,  1'b1, 7,  32'h55, 32'h55, 32'h55);
    vecs[6]  = mkVec(1'b1, cAlu, 32'h58, 7,  7,  4,  32'h1,  32'h2,  1'b0, 7,  32'h55, 32'h1,  32'h2);
    vecs[7]  = mkVec(1'b0, cAlu, 32'h5C, 1,  2,  4,  32'h7,  32'h8,  1'b0, 0,  32'h0,  32'h7,  32'h8);
    vecs[8]  = mkVec(1'b1, cLw,  32'h60, 1,  2,  10, 32'h9,  32'hA,  1'b0, 0,  32'h0,  32'h9,  32'hA);
    vecs[9]  = mkVec(1'b1, cLw,  32'h64, 11, 12, 0,  32'hB,  32'hC,  1'b0, 0,  32'h0,  32'hB,  32'hC);
    vecs[10] = mkVec(1'b1, cLw,  32'h68, 0,  0,  13, 32'hD,  32'hE,  1'b0, 0,  32'h0,  32'hD,  32'hE);
    vecs[11] = mkVec(1'b0, cAlu, 32'h6C, 13, 13, 4,  32'hF,  32'h10, 1'b0, 0,  32'h0,  32'hF,  32'h10);
    vecs[12] = mkVec(1'b1, cAlu, 32'h70, 13, 1,  4,  32'h12, 32'h13, 1'b0, 0,  32'h0,  32'h12, 32'h13);

    // Reset with holdE asserted: stallD must still read 0.
    rst_n = 1'b0;
    drive(mkVec(1'b0, 10'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 1'b0, 0, 32'd0, 32'd0, 32'd0));
    bus.flushE = 1'b0;
    bus.holdE  = 1'b1;
    #3;
    check("rst.validE", bus.validE, 32'd0);
    check("rst.ctrlE", bus.ctrlE, 32'd0);
    check("rst.pcE", bus.pcE, 32'd0);
    check("rst.bubbleCount", bus.bubbleCount, 32'd0);
    check("rst.stallD", bus.stallD, 32'd0);
    bus.holdE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d.stallD", i), bus.stallD, 32'd0);
      step();
      check($sformatf("v%0d.validE", i), bus.validE, vecs[i].expV);
      check($sformatf("v%0d.ctrlE", i), bus.ctrlE, vecs[i].ctrl);
      check($sformatf("v%0d.pcE", i), bus.pcE, vecs[i].pc);
      check($sformatf("v%0d.immE", i), bus.immE, vecs[i].imm);
      check($sformatf("v%0d.rdE", i), bus.rdE, vecs[i].rd);
      check($sformatf("v%0d.rd1E", i), bus.rd1E, vecs[i].expRd1);
      check($sformatf("v%0d.rd2E", i), bus.rd2E, vecs[i].expRd2);
    end

    // Load-use: one stall cycle, one bubble, then the consumer loads.
    drive(mkVec(1'b1, cLw, 32'h200, 1, 2, 5, 32'h1, 32'h2, 1'b0, 0, 32'h0, 32'h0, 32'h0));
    step();
    drive(mkVec(1'b1, cAlu, 32'h204, 1, 5, 6, 32'hA, 32'hB, 1'b0, 0, 32'h0, 32'h0, 32'h0));
    #1;
    check("lu.stallD", bus.stallD, 32'd1);
    step();
    check("lu.bubble.validE", bus.validE, 32'd0);
    check("lu.bubble.ctrlE", bus.ctrlE, 32'd0);
    check("lu.bubble.count", bus.bubbleCount, 32'd1);
    check("lu.bubble.pcE", bus.pcE, 32'h200);
    check("lu.bubble.stallD", bus.stallD, 32'd0);
    step();
    check("lu.next.validE", bus.validE, 32'd1);
    check("lu.next.pcE", bus.pcE, 32'h204);
    check("lu.next.rd2E", bus.rd2E, 32'hB);
    check("lu.next.count", bus.bubbleCount, 32'd1);

    // Flush overrides a pending load-use bubble.
    drive(mkVec(1'b1, cLw, 32'h300, 1, 2, 5, 32'h1, 32'h2, 1'b0, 0, 32'h0, 32'h0, 32'h0));
    step();
    drive(mkVec(1'b1, cAlu, 32'h304, 1, 5, 6, 32'hA, 32'hB, 1'b0, 0, 32'h0, 32'h0, 32'h0));
    bus.flushE = 1'b1;
    #1;
    check("fl.stallD", bus.stallD, 32'd0);
    step();
    check("fl.validE", bus.validE, 32'd0);
    check("fl.ctrlE", bus.ctrlE, 32'd0);
    check("fl.count", bus.bubbleCount, 32'd1);
    bus.flushE = 1'b0;
    #1;
    check("fl.after.stallD", bus.stallD, 32'd0);
    step();
    check("fl.after.validE", bus.validE, 32'd1);
    check("fl.after.pcE", bus.pcE, 32'h304);

    // Hold for three cycles with a writeback to rs1E in the middle one.
    drive(mkVec(1'b1, cAlu, 32'hC0, 7, 2, 8, 32'h10, 32'h20, 1'b0, 0, 32'h0, 32'h0, 32'h0));
    step();
    drive(mkVec(1'b1, cLw, 32'hDEAD, 7, 3, 9, 32'hEE, 32'hFF, 1'b0, 0, 32'h0, 32'h0, 32'h0));
    bus.holdE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.wbRegWrite = (c == 1);
      bus.wbRd       = (c == 1) ? 5'd7 : 5'd0;
      bus.wbData     = (c == 1) ? 32'h99 : 32'h0;
      #1;
      check($sformatf("hold%0d.stallD", c), bus.stallD, 32'd1);
      step();
      check($sformatf("hold%0d.pcE", c), bus.pcE, 32'hC0);
      check($sformatf("hold%0d.ctrlE", c), bus.ctrlE, cAlu);
      check($sformatf("hold%0d.rd1E", c), bus.rd1E, (c == 0) ? 32'h10 : 32'h99);
      check($sformatf("hold%0d.rd2E", c), bus.rd2E, 32'h20);
    end
    bus.holdE = 1'b0;
    bus.wbRegWrite = 1'b0;

    // Three more bubbles (one delayed by a hold), ending in BUB with count 4.
    for (int i = 0; i < 3; i++) begin
      drive(mkVec(1'b1, cLw, 32'h400 + 32'(i * 16), 1, 2, 5, 32'h1, 32'h2, 1'b0, 0, 32'h0, 32'h0, 32'h0));
      step();
      drive(mkVec(1'b1, cAlu, 32'h404 + 32'(i * 16), 5, 3, 6, 32'hA, 32'hB, 1'b0, 0, 32'h0, 32'h0, 32'h0));
      if (i == 1) begin
        bus.holdE = 1'b1;
        step();
        check("bub.hold.validE", bus.validE, 32'd1);
        check("bub.hold.count", bus.bubbleCount, 32'd2);
        bus.holdE = 1'b0;
      end
      step();
      check($sformatf("bub%0d.count", i), bus.bubbleCount, 32'(2 + i));
      check($sformatf("bub%0d.validE", i), bus.validE, 32'd0);
      if (i < 2) step();
    end

    // Asynchronous reset while in BUB: outputs clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.validE", bus.validE, 32'd0);
    check("arst.ctrlE", bus.ctrlE, 32'd0);
    check("arst.pcE", bus.pcE, 32'd0);
    check("arst.rdE", bus.rdE, 32'd0);
    check("arst.rd1E", bus.rd1E, 32'd0);
    check("arst.count", bus.bubbleCount, 32'd0);
    check("arst.stallD", bus.stallD, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mkVec(1'b1, cAlu, 32'h500, 5, 5, 6, 32'h31, 32'h32, 1'b0, 0, 32'h0, 32'h0, 32'h0));
    step();
    check("post.validE", bus.validE, 32'd1);
    check("post.pcE", bus.pcE, 32'h500);
    check("post.rd1E", bus.rd1E, 32'h31);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Parameter: CTRLW, 10, control bundle width; bit fields are defined in the shared package.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 validD  in  1  decode stage holds a real instruction.
REQ-006 ctrlD  in  CTRLW  {regWrite, memRead, memWrite, aluSrc, aluOp[2:0], resultSrc[1:0], branch}.
REQ-007 pcD, immD  in  XLEN  decode PC and immediate.
REQ-008 rs1D, rs2D, rdD  in  5  decode register indices.
REQ-009 readData1, readData2  in  XLEN  register-file read data, valid before posedge.
REQ-010 wbRegWrite  in  1; wbRd  in  5; wbData  in  XLEN  writeback-port copy.
REQ-011 flushE  in  1  kill the EX-stage slot (branch/jump redirect).
REQ-012 holdE  in  1  downstream back-pressure; freeze the EX slot.
REQ-013 stallD  out  1  freeze PC and IF/ID this cycle (combinational).
REQ-014 validE, ctrlE, pcE, immE, rs1E, rs2E, rdE, rd1E, rd2E  out  registered EX-slot contents.
REQ-015 bubbleCount  out  16  count of inserted load-use bubbles, saturating.

Function
REQ-016 Priority on each posedge: flushE > holdE > load-use bubble > normal load.
REQ-017 Normal load: every E register takes its D input, with 1-cycle latency.
REQ-018 Writeback bypass: when wbRegWrite is high, wbRd != 0 and wbRd == rs1D, rd1E SHALL take wbData instead of readData1; rs2D/rd2E follow the same rule. The bypass exists because the register file reads and writes on the same edge and returns stale data.
REQ-019 Index 0 SHALL never bypass; the loaded value is readData as presented.
REQ-020 hazLU = validE & ctrlE.memRead & (rdE != 0) & validD & ((rdE == rs1D) | (rdE == rs2D)).
REQ-021 stallD = hazLU | holdE, and stallD SHALL be forced to 0 whenever flushE is high.
REQ-022 Bubble: when hazLU is high and neither flushE nor holdE is high, validE and ctrlE SHALL load 0; data fields are don't-care and SHALL hold their values.
REQ-023 FSM, two states. RUN -> BUB on bubble insertion. BUB -> RUN on the next non-hold edge. BUB with holdE stays in BUB.
REQ-024 In BUB, hazLU is inherently 0; a second consecutive bubble for the same pair SHALL NOT occur.
REQ-025 Flush: validE=0 and ctrlE=0, the state goes to RUN, the pending bubble is dropped, and bubbleCount is not incremented.
REQ-026 Hold: all E registers keep their values, except that rd1E/rd2E SHALL refresh from wbData when wbRegWrite is high, wbRd != 0 and wbRd equals rs1E/rs2E.
REQ-027 bubbleCount increments by 1 per inserted bubble and saturates at 16'hFFFF.
REQ-028 A bubble SHALL be inserted only if ctrlE=0 produces no memory or register side effects downstream.

Reset
REQ-029 While rst_n is low, asynchronously: validE=0, ctrlE=0, all data/index outputs 0, bubbleCount=0, state=RUN.
REQ-030 stallD SHALL be 0 during reset.
REQ-031 On deassertion, the first posedge performs a normal load.

Structure
REQ-032 The shared package (cpu_pkg) holds the CTRLW field offsets, the aluOp/resultSrc encodings, and the FSM state enum.
REQ-033 One sub-module, wb_bypass, instantiated twice (one per source operand). It is combinational: inputs rs, rf data, wbRegWrite, wbRd, wbData; output is the selected data.
REQ-034 Target size: 150-250 lines of RTL.

Verification
REQ-035 Plain load: pcD=0x40, readData1=5, no hazards -> next cycle pcE=0x40, rd1E=5, validE=1.
REQ-036 Bypass: rs1D=3, readData1=0x11, wbRegWrite=1, wbRd=3, wbData=0x22 -> rd1E=0x22. Repeat with wbRd=0 -> rd1E=0x11.
REQ-037 Load-use: EX holds lw with rdE=5 and memRead=1; ID presents rs2D=5 -> stallD=1 for exactly one cycle, then validE=0 and ctrlE=0, bubbleCount=1; the next cycle loads the ID instruction.
REQ-038 Flush during hazard: same setup as REQ-037 with flushE=1 -> stallD=0, validE=0, bubbleCount unchanged, state=RUN.
REQ-039 Hold with refresh: holdE=1 for 3 cycles with rs1E=7; cycle 2 has wbRd=7, wbData=0x99 -> E fields frozen, rd1E=0x99, stallD=1 throughout.
REQ-040 Reset mid-operation: assert rst_n=0 while in BUB with bubbleCount=4 -> all outputs 0 immediately, without waiting for a clock edge.
